// File: rtl/iq_rxd_packer_pkg.sv
// Shared constants, state encoding and word-padding helper for the IQ receive packer.
package iq_rxd_packer_pkg;

    localparam int unsigned DEF_FRAME_WORDS = 12;
    localparam int unsigned SYM_PER_WORD    = 16;
    localparam int unsigned WORD_W          = 32;

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StRun
    } state_e;

    // Left-justify the n most recent symbols held in the low bits of shift; zero-fill below.
    function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] shift,
                                                   input logic [3:0]        n);
        logic [4:0] gap;
        gap = 5'(SYM_PER_WORD) - {1'b0, n};
        return shift << {gap, 1'b0};
    endfunction

endpackage

// File: rtl/iq_rxd_packer_if.sv
// AXI-Stream word channel carrying packed IQ words out of the packer.
interface iq_rxd_packer_if
    import iq_rxd_packer_pkg::*;
();
    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/iq_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// The head register mirrors the oldest stored entry, so total capacity stays DEPTH.
module iq_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_after_pop;
    logic             pop, accept;

    assign full          = (cnt_q == CNT_W'(DEPTH));
    assign pop           = head_valid & ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign accept        = push & (~full | pop);
    assign rd_nxt        = rd_ptr_q + PTR_W'(pop);
    assign cnt_after_pop = cnt_q - CNT_W'(pop);

    // Storage array; no reset needed since occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= push_data;
    end

    // Pointers, occupancy and the registered head (reflects state before this edge's push).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q   <= rd_nxt;
            cnt_q      <= cnt_after_pop + CNT_W'(accept);
            head_valid <= (cnt_after_pop != '0);
            if (cnt_after_pop != '0) head_data <= mem_q[rd_nxt];
        end
    end

endmodule

// File: rtl/iq_rxd_packer.sv
// Packs 2-bit IQ line symbols into 32-bit words, frames them with tlast and
// streams them out through a small FIFO as an AXI-Stream master.
module iq_rxd_packer
    import iq_rxd_packer_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk32,
    input  logic                   reset,
    input  logic [1:0]             iq_rxd,
    input  logic                   iq_valid,
    input  logic                   clr_flags,
    iq_rxd_packer_if.master        m_axis,
    output logic                   overflow,
    output logic                   frame_err
);
    localparam int unsigned WC_W = $clog2(FRAME_WORDS + 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d, pend_q, pend_d, skid_q, skid_d;
    logic [3:0]          sym_cnt_q, sym_cnt_d;
    logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
    logic                pend_v_q, pend_v_d, skid_v_q, skid_v_d;
    logic                overflow_q, overflow_d, frame_err_q, frame_err_d;

    logic                cap, word_done, early_pad, wc_last, fifo_full, pop;
    logic                wr_en, wr_last, is_pad;
    logic [WORD_W-1:0]   wr_data, full_word, padded;
    logic [WORD_W:0]     head_data;

    assign cap       = iq_valid & (state_q != StSync);
    assign word_done = cap & (sym_cnt_q == 4'(SYM_PER_WORD - 1));
    assign full_word = {shift_q[WORD_W-3:0], iq_rxd};
    assign early_pad = (state_q == StRun) & ~iq_valid & (sym_cnt_q != '0);
    assign padded    = pad_word(shift_q, sym_cnt_q);
    assign wc_last   = (word_cnt_q == WC_W'(FRAME_WORDS - 1));
    assign pop       = m_axis.tvalid & m_axis.tready;

    // Capture FSM, shift register and completed-word staging.
    always_comb begin
        state_d   = state_q;
        unique case (state_q)
            StSync:  if (!iq_valid) state_d = StIdle;
            StIdle:  if (iq_valid)  state_d = StRun;
            StRun:   if (!iq_valid) state_d = StIdle;
            default: state_d = StSync;
        endcase
        shift_d   = cap ? full_word : shift_q;
        sym_cnt_d = cap ? sym_cnt_q + 4'd1 : 4'd0;
        pend_d    = word_done ? full_word : pend_q;
        pend_v_d  = word_done;
    end

    // FIFO write arbitration: pend first, then the skid slot, then a fresh padded word.
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        is_pad   = 1'b0;
        skid_d   = skid_q;
        skid_v_d = 1'b0;
        if (pend_v_q) begin
            wr_en   = 1'b1;
            wr_data = pend_q;
            wr_last = ~early_pad & (wc_last | ~iq_valid);
            if (early_pad) begin
                skid_v_d = 1'b1;
                skid_d   = padded;
            end
        end else if (skid_v_q) begin
            wr_en   = 1'b1;
            wr_data = skid_q;
            wr_last = 1'b1;
            is_pad  = 1'b1;
        end else if (early_pad) begin
            wr_en   = 1'b1;
            wr_data = padded;
            wr_last = 1'b1;
            is_pad  = 1'b1;
        end
    end

    // Frame word counting and sticky flags; a new event beats clr_flags.
    always_comb begin
        word_cnt_d  = word_cnt_q;
        if (wr_en) word_cnt_d = wr_last ? '0 : word_cnt_q + WC_W'(1);
        overflow_d  = (wr_en & fifo_full & ~pop) | (overflow_q & ~clr_flags);
        frame_err_d = (wr_en & ((wr_last & ~wc_last) | is_pad)) | (frame_err_q & ~clr_flags);
    end

    // State registers.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_q     <= StSync;
            shift_q     <= '0;
            sym_cnt_q   <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            skid_q      <= '0;
            skid_v_q    <= 1'b0;
            word_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            sym_cnt_q   <= sym_cnt_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            skid_q      <= skid_d;
            skid_v_q    <= skid_v_d;
            word_cnt_q  <= word_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    iq_sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk32),
        .reset      (reset),
        .push       (wr_en),
        .push_data  ({wr_last, wr_data}),
        .ready      (m_axis.tready),
        .full       (fifo_full),
        .head_valid (m_axis.tvalid),
        .head_data  (head_data)
    );

    assign m_axis.tdata = head_data[WORD_W-1:0];
    assign m_axis.tlast = head_data[WORD_W];
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule
